// File: rtl/output_pixel_buffer_if.sv
// Bus-side bundle for output_pixel_buffer: rotate-core byte writes, word read
// handshake and buffer status.
interface output_pixel_buffer_if #(
  parameter int DEPTH = 64
);
  localparam int WORDS = DEPTH / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          I_PIXEL_WE;
  logic [7:0]    I_PIXEL_B;
  logic [7:0]    I_PIXEL_G;
  logic [7:0]    I_PIXEL_R;
  logic [7:0]    I_PIXEL_ADDRB;
  logic [7:0]    I_PIXEL_ADDRG;
  logic [7:0]    I_PIXEL_ADDRR;
  logic          I_CLEAR;
  logic          I_RD_REQ;
  logic [AW-1:0] I_RD_ADDR;
  logic [31:0]   O_HRDATA;
  logic          O_RD_VALID;
  logic          O_RD_BUSY;
  logic [CW-1:0] O_FILL_COUNT;
  logic          O_FULL;
  logic          O_EMPTY;
  logic          O_OVERWRITE;

  modport master (
    output I_PIXEL_WE, I_PIXEL_B, I_PIXEL_G, I_PIXEL_R,
    output I_PIXEL_ADDRB, I_PIXEL_ADDRG, I_PIXEL_ADDRR,
    output I_CLEAR, I_RD_REQ, I_RD_ADDR,
    input  O_HRDATA, O_RD_VALID, O_RD_BUSY, O_FILL_COUNT,
    input  O_FULL, O_EMPTY, O_OVERWRITE
  );

  modport slave (
    input  I_PIXEL_WE, I_PIXEL_B, I_PIXEL_G, I_PIXEL_R,
    input  I_PIXEL_ADDRB, I_PIXEL_ADDRG, I_PIXEL_ADDRR,
    input  I_CLEAR, I_RD_REQ, I_RD_ADDR,
    output O_HRDATA, O_RD_VALID, O_RD_BUSY, O_FILL_COUNT,
    output O_FULL, O_EMPTY, O_OVERWRITE
  );
endinterface

// File: rtl/output_pixel_buffer.sv
// Output pixel buffer: byte-addressed writes from the rotate core, 32-bit word
// reads that stall until the word is complete and then consume its valid bits.
module output_pixel_buffer #(
  parameter int DEPTH = 64
) (
  input  logic                  I_HCLK,
  input  logic                  I_HRESET_N,
  output_pixel_buffer_if.slave  bus
);
  localparam int WORDS = DEPTH / 4;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int IW    = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q [DEPTH];
  logic [7:0]       data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, valid_wr, wr_hit;
  logic [AW-1:0]    addr_q, addr_d, look_addr;
  logic [31:0]      hrdata_q, hrdata_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;
  logic             overwrite_q, overwrite_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             hit_b, hit_g, hit_r;
  logic             complete, consume;
  logic [3:0]       word_valid;
  logic [31:0]      word_data;

  // Later writes in this block take priority, so R beats G beats B on a shared address.
  always_comb begin
    hit_b  = bus.I_PIXEL_WE && ({1'b0, bus.I_PIXEL_ADDRB} < DEPTH_L);
    hit_g  = bus.I_PIXEL_WE && ({1'b0, bus.I_PIXEL_ADDRG} < DEPTH_L);
    hit_r  = bus.I_PIXEL_WE && ({1'b0, bus.I_PIXEL_ADDRR} < DEPTH_L);
    data_d = data_q;
    wr_hit = '0;
    if (hit_b) begin
      data_d[bus.I_PIXEL_ADDRB[IW-1:0]] = bus.I_PIXEL_B;
      wr_hit[bus.I_PIXEL_ADDRB[IW-1:0]] = 1'b1;
    end
    if (hit_g) begin
      data_d[bus.I_PIXEL_ADDRG[IW-1:0]] = bus.I_PIXEL_G;
      wr_hit[bus.I_PIXEL_ADDRG[IW-1:0]] = 1'b1;
    end
    if (hit_r) begin
      data_d[bus.I_PIXEL_ADDRR[IW-1:0]] = bus.I_PIXEL_R;
      wr_hit[bus.I_PIXEL_ADDRR[IW-1:0]] = 1'b1;
    end
    valid_wr    = (bus.I_CLEAR ? '0 : valid_q) | wr_hit;
    overwrite_d = overwrite_q | (|(wr_hit & valid_q));
  end

  // Completeness and read data both see this cycle's writes (forwarding).
  always_comb begin
    look_addr  = (state_q == WAIT) ? addr_q : bus.I_RD_ADDR;
    word_valid = valid_wr[int'(look_addr)*4 +: 4];
    word_data  = {data_d[int'(look_addr)*4 + 3], data_d[int'(look_addr)*4 + 2],
                  data_d[int'(look_addr)*4 + 1], data_d[int'(look_addr)*4]};
    complete   = &word_valid;

    state_d    = state_q;
    addr_d     = addr_q;
    hrdata_d   = hrdata_q;
    rd_valid_d = 1'b0;
    busy_d     = 1'b0;
    consume    = 1'b0;
    case (state_q)
      WAIT: begin
        if (complete) begin
          state_d    = DATA;
          consume    = 1'b1;
          hrdata_d   = word_data;
          rd_valid_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        if (bus.I_RD_REQ) begin
          addr_d = bus.I_RD_ADDR;
          if (complete) begin
            state_d    = DATA;
            consume    = 1'b1;
            hrdata_d   = word_data;
            rd_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    valid_d = valid_wr;
    if (consume) valid_d[int'(look_addr)*4 +: 4] = 4'b0000;
    fill_d = '0;
    for (int i = 0; i < DEPTH; i++) fill_d = fill_d + CW'(valid_d[i]);
  end

  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      hrdata_q    <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overwrite_q <= 1'b0;
      fill_q      <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      hrdata_q    <= hrdata_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      overwrite_q <= overwrite_d;
      fill_q      <= fill_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  assign bus.O_HRDATA     = hrdata_q;
  assign bus.O_RD_VALID   = rd_valid_q;
  assign bus.O_RD_BUSY    = busy_q;
  assign bus.O_FILL_COUNT = fill_q;
  assign bus.O_FULL       = (fill_q == CW'(DEPTH));
  assign bus.O_EMPTY      = (fill_q == '0);
  assign bus.O_OVERWRITE  = overwrite_q;
endmodule

// File: doc/output_pixel_buffer.md
Name: output_pixel_buffer

Overview:
- Output-side pixel buffer for the rotate datapath; the mirror of the AHB-written input pixel store.
- Rotate core writes three bytes per cycle (B, G, R to independent byte addresses); the bus side reads packed 32-bit words.
- Per-byte valid bits track completeness. A read stalls until all four bytes of the requested word are valid, then returns the word and consumes it.

Parameters:
- DEPTH, 64, buffer size in bytes (multiple of 4)
- WORDS, DEPTH/4, number of 32-bit words (derived, not overridable)

Ports:
- I_HCLK  input  1  clock, all state on rising edge
- I_HRESET_N  input  1  asynchronous active-low reset
- I_PIXEL_WE  input  1  pixel write strobe
- I_PIXEL_B  input  8  blue byte
- I_PIXEL_G  input  8  green byte
- I_PIXEL_R  input  8  red byte
- I_PIXEL_ADDRB  input  8  byte address for blue
- I_PIXEL_ADDRG  input  8  byte address for green
- I_PIXEL_ADDRR  input  8  byte address for red
- I_CLEAR  input  1  synchronous clear of all valid bits
- I_RD_REQ  input  1  word read request
- I_RD_ADDR  input  clog2(WORDS)  word index
- O_HRDATA  output  32  read data; byte 4w+k on bits [8k+7:8k]
- O_RD_VALID  output  1  one-cycle pulse, O_HRDATA valid
- O_RD_BUSY  output  1  request pending, word incomplete
- O_FILL_COUNT  output  clog2(DEPTH)+1  number of valid bytes
- O_FULL  output  1  O_FILL_COUNT == DEPTH
- O_EMPTY  output  1  O_FILL_COUNT == 0
- O_OVERWRITE  output  1  sticky: write hit an already-valid byte

Behaviour:
- Reset (async, I_HRESET_N low):
  - All data bytes, valid bits and O_HRDATA go to 0.
  - O_RD_VALID, O_RD_BUSY and O_OVERWRITE go to 0; O_FILL_COUNT goes to 0, so O_EMPTY=1 and O_FULL=0.
  - FSM goes to IDLE.
  - Reset during WAIT drops the pending request with no O_RD_VALID.
- Write: when I_PIXEL_WE=1, each byte whose address is < DEPTH is stored and its valid bit set. Addresses >= DEPTH are silently ignored.
- Duplicate addresses in one cycle: R overrides G, G overrides B; the byte counts once in the fill count.
- Overwrite: writing a byte whose valid bit is already set stores the new data and sets O_OVERWRITE. Only reset clears O_OVERWRITE.
- Word complete: all 4 valid bits set, counting bytes written in the same cycle.
- FSM states: IDLE, WAIT, DATA.
  - IDLE/DATA with I_RD_REQ=1: latch I_RD_ADDR.
    - If the word is complete (including same-cycle writes, forwarded into the data), go to DATA. Next cycle: O_HRDATA = word, O_RD_VALID=1.
    - Else go to WAIT with O_RD_BUSY=1 from the next cycle.
  - IDLE/DATA with I_RD_REQ=0: go to IDLE.
  - WAIT: I_RD_REQ is ignored. Each cycle re-evaluate completeness of the latched word, including same-cycle writes. When complete, go to DATA; O_RD_BUSY drops in the same cycle O_RD_VALID rises.
  - DATA: O_RD_VALID=1 for exactly this cycle. Back-to-back requests are accepted here, giving a 1-per-cycle throughput.
- Latency: a request to a complete word at cycle N gives O_RD_VALID at N+1.
- Consume: on the transition into DATA, the four valid bits of the word are cleared. This includes bytes written in that same cycle (forwarded and consumed). Data bytes are retained.
- I_CLEAR:
  - Clears all valid bits.
  - A write in the same cycle wins for its bytes.
  - Does not change FSM state; a WAIT request keeps waiting.
  - Does not clear O_OVERWRITE.
- O_FILL_COUNT is registered and equals the popcount of the valid bits after the edge. Max value DEPTH, no wrap.
- O_HRDATA holds its last value outside O_RD_VALID.

Test Plan:
- Fill 0..3 over two cycles (B=0x11@0, G=0x22@1, R=0x33@2, then B=0x44@3), RD_REQ addr 0 next cycle → O_RD_VALID one cycle later, O_HRDATA=0x44332211, fill 4→0, O_EMPTY=1.
- RD_REQ addr 1 on empty buffer → O_RD_BUSY=1; write bytes 4..6 then 7 (0xA0..0xA3) over 2 cycles → O_RD_VALID the cycle after byte 7, O_HRDATA=0xA3A2A1A0, BUSY falls simultaneously.
- Word 2 holds 3 bytes; request it in the same cycle byte 11 (0x5C) is written → forwarded, O_RD_VALID at N+1, bits[31:24]=0x5C, fill count excludes word 2.
- Write the same address 5 with B=0x01, G=0x02, R=0x03 in one cycle → byte 5 = 0x03, fill +1, O_OVERWRITE=0; rewrite byte 5 → O_OVERWRITE=1 sticky through I_CLEAR.
- Write all 64 bytes → O_FULL=1, count=64; write addr 0x40 → ignored, count unchanged; I_CLEAR → count 0, O_EMPTY=1.
- Assert I_HRESET_N low asynchronously mid-WAIT → outputs 0 immediately, no O_RD_VALID after release; back-to-back reads of words 0,1 (pre-filled) → O_RD_VALID high two consecutive cycles.
